mem_image_sequencer: RTL and testbench
======================================

# mem_image_sequencer

Synthesizable on-chip loader, run controller and dumper that sits directly upstream of the RV32ICore debug ports (`*_A2`/`*_WD2`/`*_WE2`/`*_RD2`). It does three things in order:

- Takes a word stream (data image, then instruction image) and writes it into the Data and Inst BRAMs.
- Holds the core in reset, then releases it for a fixed run window.
- Reads back both BRAMs in full and streams their contents out for dumping.

## Interface
- `BRAMWORDS`, 4096, words per BRAM (32-bit words).
- `RST_CYCLES`, 5, minimum cycles `core_rst` is held after loading, before the run.
- `RUN_CYCLES`, 200000, cycles the core runs with `core_rst` low.
- `CPU_CLK`  in  1  the single clock.
- `CPU_RST`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a sequence.
- `in_valid`  in  1  image word valid.
- `in_ready`  out  1  image word accepted.
- `in_data`  in  32  image word.
- `in_last`  in  1  marks the final word of the current segment (data image, then inst image).
- `dcache_a2`  out  32  Data BRAM debug byte address.
- `dcache_wd2`  out  32  Data BRAM debug write data.
- `dcache_we2`  out  4  Data BRAM debug byte write enables.
- `dcache_rd2`  in  32  Data BRAM debug read data; 1-cycle read latency.
- `icache_a2`, `icache_wd2`, `icache_we2`, `icache_rd2`: same as the four `dcache_*` ports, for the Inst BRAM.
- `core_rst`  out  1  drives the core's reset.
- `out_valid`  out  1  dump word valid.
- `out_ready`  in  1  dump word consumed.
- `out_data`  out  32  dump word.
- `out_sel`  out  1  0 = Data BRAM, 1 = Inst BRAM.
- `out_last`  out  1  final word of the current segment.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sequence complete.

## Operation
- **States:** IDLE, LOAD_D, LOAD_I, HOLD, RUN, DUMP_D, DUMP_I, DONE.
- **IDLE / DONE:** `start` enters LOAD_D and clears the word index `k`. `start` is ignored in every other state.
- **LOAD_D / LOAD_I:**
  - `in_ready` = 1.
  - Each handshake writes `in_data` at address 4·k, `we2` = 4'b1111, for one cycle on the selected BRAM, then increments `k`.
  - The segment ends on a handshake with `in_last`, or on the handshake at k = BRAMWORDS−1, whichever comes first.
  - On segment end: LOAD_D → LOAD_I, LOAD_I → HOLD, and `k` clears.
  - Unwritten words keep their previous contents; there is no zero-fill.
- **HOLD:** waits RST_CYCLES cycles, then RUN.
- **RUN:** `core_rst` = 0 for exactly RUN_CYCLES cycles, then DUMP_D.
- **DUMP_D / DUMP_I:** for k = 0..BRAMWORDS−1, three sub-phases:
  - ADDR: drive `a2` = 4·k for one cycle.
  - CAPT: register `rd2` into `out_data`.
  - SEND: hold `out_valid` = 1 until `out_ready`.
  - `out_last` is asserted when k = BRAMWORDS−1.
  - DUMP_D → DUMP_I → DONE.
- **core_rst:** 1 in every state except RUN.
- **we2:** 4'b0000 except on load handshakes.
- **a2 / wd2:** `a2` = 0 and `wd2` = 0 outside LOAD and DUMP.
- **Status:** `busy` = 1 in LOAD_D through DUMP_I. `done` = 1 only in DONE.
- **Counters:**
  - `k`: $clog2(BRAMWORDS)+1 bits.
  - Cycle counter: $clog2(RUN_CYCLES)+1 bits.
  - Addresses: {k, 2'b00}, zero-extended to 32 bits.
- **Reset, including mid-sequence:** state goes to IDLE immediately.
  - Reset values: `core_rst` = 1, `in_ready` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `done` = 0.
  - All `a2`/`wd2`/`out_data` = 0, `we2` = 0, `out_sel` = 0.

## Timing
- Load: one word per cycle while `in_valid` is held; the write appears on `we2`/`a2` in the cycle after the handshake.
- `in_last` together with k = BRAMWORDS−1 counts as a single segment end.
- Segment boundary: the first LOAD_I handshake can occur in the cycle immediately after the last LOAD_D handshake.
- Load → run: `core_rst` falls RST_CYCLES+1 cycles after the final LOAD_I handshake.
- Run → dump: `core_rst` rises RUN_CYCLES cycles after it falls; ADDR of k = 0 is in that same cycle.
- Dump: at most one word per 3 cycles. While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_sel` and `out_last` are stable.
- DONE is entered the cycle after the `out_last` handshake of DUMP_I.

## Structure
- `mem_seq_pkg`: state encoding localparams, dump sub-phase encoding, `SEG_DATA` = 0, `SEG_INST` = 1.
- One sub-module, `bram_dump_reader`: ADDR/CAPT/SEND for one segment, with a start/last handshake. It is instantiated once and muxed onto the D or I port by `out_sel`.

## Test plan
All scenarios use BRAMWORDS = 8, RST_CYCLES = 3, RUN_CYCLES = 20.

1. **Short load:** `start`; data words 11,22,33 (`in_last` on 33); inst words AA,BB (`in_last` on BB).
   - Data BRAM writes 0→11, 4→22, 8→33; Inst BRAM writes 0→AA, 4→BB, all with `we2` = F.
   - `core_rst` falls 4 cycles after BB, stays low 20 cycles, then rises.
2. **Full segment without `in_last`:** 8 data words, then one inst word with `in_last`.
   - Auto-advance after the 8th word (address 0x1C); the next word goes to `icache` address 0.
3. **Dump with back-pressure:** random `out_ready` (about 30% high).
   - 16 words, in order: data then inst, addresses 0..0x1C.
   - Contents match the loaded values.
   - `out_last` on the 8th and 16th words; outputs stable while stalled.
4. **Asynchronous reset mid-RUN:** `CPU_RST` pulse.
   - Same cycle: `core_rst` = 1, `busy` = 0, all `we2` = 0.
   - Back in IDLE; the next `start` reloads from address 0.
5. **`start` handling:**
   - `start` during LOAD_I or RUN: no effect.
   - `start` in DONE: `done` drops and LOAD_D begins.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory image sequencer: top-level states, dump
// sub-phases and BRAM segment selectors.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_D = 3'd1,
    S_LOAD_I = 3'd2,
    S_HOLD   = 3'd3,
    S_RUN    = 3'd4,
    S_DUMP_D = 3'd5,
    S_DUMP_I = 3'd6,
    S_DONE   = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ADDR = 2'd1,
    PH_CAPT = 2'd2,
    PH_SEND = 2'd3
  } dump_phase_t;

  localparam logic SEG_DATA = 1'b0;
  localparam logic SEG_INST = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bram_dump_reader.sv
// Walks one BRAM segment word by word: drive address, capture read data,
// then present it on a valid/ready output until consumed.
module bram_dump_reader
  import mem_seq_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int KW    = $clog2(WORDS) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_addr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        seg_done
);

  dump_phase_t   phase_q, phase_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   data_q, data_d;
  logic          at_end;

  assign at_end    = (k_q == KW'(WORDS - 1));
  assign out_valid = (phase_q == PH_SEND);
  assign out_last  = out_valid && at_end;
  assign out_data  = data_q;
  assign seg_done  = out_valid && out_ready && at_end;
  assign rd_addr   = (phase_q == PH_ADDR) ? 32'({k_q, 2'b00}) : 32'd0;

  always_comb begin
    phase_d = phase_q;
    k_d     = k_q;
    data_d  = data_q;
    case (phase_q)
      PH_ADDR: phase_d = PH_CAPT;
      PH_CAPT: begin
        data_d  = rd_data;
        phase_d = PH_SEND;
      end
      PH_SEND: begin
        if (out_ready) begin
          if (at_end) begin
            phase_d = PH_IDLE;
          end else begin
            k_d     = k_q + KW'(1);
            phase_d = PH_ADDR;
          end
        end
      end
      default: ;
    endcase
    // A new segment may be launched on the same edge the previous one ends.
    if (start) begin
      phase_d = PH_ADDR;
      k_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      k_q     <= '0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      k_q     <= k_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mem_image_sequencer.sv
// Loads data and instruction images into the core's BRAMs, runs the core for
// a fixed window, then streams both BRAMs back out.
module mem_image_sequencer
  import mem_seq_pkg::*;
#(
  parameter int BRAMWORDS  = 4096,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 200000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] dcache_a2,
  output logic [31:0] dcache_wd2,
  output logic [3:0]  dcache_we2,
  input  logic [31:0] dcache_rd2,
  output logic [31:0] icache_a2,
  output logic [31:0] icache_wd2,
  output logic [3:0]  icache_we2,
  input  logic [31:0] icache_rd2,
  output logic        core_rst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sel,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int KW = $clog2(BRAMWORDS) + 1;
  localparam int CW = $clog2(max_int(RUN_CYCLES, RST_CYCLES)) + 1;

  seq_state_t    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [3:0]    wr_we_q, wr_we_d;
  logic          wr_sel_q, wr_sel_d;

  logic          load_hs;
  logic          seg_end;
  logic          run_end;
  logic          reader_start;
  logic          seg_done;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_mux;

  assign in_ready = (state_q == S_LOAD_D) || (state_q == S_LOAD_I);
  assign load_hs  = in_ready && in_valid;
  assign seg_end  = in_last || (k_q == KW'(BRAMWORDS - 1));
  assign run_end  = (state_q == S_RUN) && (cnt_q == CW'(RUN_CYCLES - 1));
  assign core_rst = (state_q != S_RUN);
  assign busy     = state_q inside {S_LOAD_D, S_LOAD_I, S_HOLD, S_RUN, S_DUMP_D, S_DUMP_I};
  assign done     = (state_q == S_DONE);
  assign out_sel  = (state_q == S_DUMP_I) ? SEG_INST : SEG_DATA;
  assign rd_mux   = (out_sel == SEG_INST) ? icache_rd2 : dcache_rd2;

  // The reader's ADDR phase must coincide with the first dump cycle, so it is
  // launched on the edge that leaves RUN or finishes the data segment.
  assign reader_start = run_end || ((state_q == S_DUMP_D) && seg_done);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_we_d   = '0;
    wr_sel_d  = wr_sel_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD_D;
          k_d     = '0;
        end
      end
      S_LOAD_D, S_LOAD_I: begin
        if (load_hs) begin
          wr_addr_d = 32'({k_q, 2'b00});
          wr_data_d = in_data;
          wr_we_d   = 4'hF;
          wr_sel_d  = (state_q == S_LOAD_I) ? SEG_INST : SEG_DATA;
          if (seg_end) begin
            k_d     = '0;
            cnt_d   = '0;
            state_d = (state_q == S_LOAD_D) ? S_LOAD_I : S_HOLD;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (run_end) begin
          cnt_d   = '0;
          state_d = S_DUMP_D;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DUMP_D: if (seg_done) state_d = S_DUMP_I;
      S_DUMP_I: if (seg_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_we_q   <= '0;
      wr_sel_q  <= SEG_DATA;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_we_q   <= wr_we_d;
      wr_sel_q  <= wr_sel_d;
    end
  end

  // Write registers are zero outside a write cycle, so the load and dump
  // paths can share the debug ports without further qualification.
  always_comb begin
    dcache_a2  = '0;
    dcache_wd2 = '0;
    dcache_we2 = '0;
    icache_a2  = '0;
    icache_wd2 = '0;
    icache_we2 = '0;
    if (wr_sel_q == SEG_DATA) begin
      dcache_a2  = wr_addr_q;
      dcache_wd2 = wr_data_q;
      dcache_we2 = wr_we_q;
    end else begin
      icache_a2  = wr_addr_q;
      icache_wd2 = wr_data_q;
      icache_we2 = wr_we_q;
    end
    if (state_q == S_DUMP_D) begin
      dcache_a2 = rd_addr;
    end else if (state_q == S_DUMP_I) begin
      icache_a2 = rd_addr;
    end
  end

  bram_dump_reader #(
    .WORDS(BRAMWORDS)
  ) u_reader (
    .clk      (CPU_CLK),
    .rst      (CPU_RST),
    .start    (reader_start),
    .rd_data  (rd_mux),
    .rd_addr  (rd_addr),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .seg_done (seg_done)
  );

endmodule

// File: tb/tb_mem_image_sequencer.sv
// Randomized bench for mem_image_sequencer with behavioural BRAMs and an
// image-level reference of expected writes, run timing and dump contents.
module tb_mem_image_sequencer;

  localparam int W    = 8;
  localparam int RSTC = 3;
  localparam int RUNC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [31:0] d_a2, d_wd2, i_a2, i_wd2, out_data;
  logic [31:0] d_rd2 = '0;
  logic [31:0] i_rd2 = '0;
  logic [3:0]  d_we2, i_we2;
  logic        core_rst, out_valid, out_sel, out_last, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] dmem [W];
  logic [31:0] imem [W];
  logic [31:0] exp_mem [2][W];

  logic        log_sel [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_we [$];
  logic [31:0] dump_data [$];
  logic        dump_sel [$];
  logic        dump_last [$];

  logic rst_prev = 1'b1;
  int   fall_cyc = -1;
  int   rise_cyc = -1;
  int   first_valid_cyc = -1;
  int   unstable = 0;
  int   min_gap = 1000;

  mem_image_sequencer #(
    .BRAMWORDS(W), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC)
  ) dut (
    .CPU_CLK(clk), .CPU_RST(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dcache_a2(d_a2), .dcache_wd2(d_wd2), .dcache_we2(d_we2), .dcache_rd2(d_rd2),
    .icache_a2(i_a2), .icache_wd2(i_wd2), .icache_we2(i_we2), .icache_rd2(i_rd2),
    .core_rst(core_rst), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural BRAMs with byte enables and one-cycle registered read.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (d_we2[b]) dmem[d_a2[4:2]][8*b +: 8] <= d_wd2[8*b +: 8];
      if (i_we2[b]) imem[i_a2[4:2]][8*b +: 8] <= i_wd2[8*b +: 8];
    end
    d_rd2 <= dmem[d_a2[4:2]];
    i_rd2 <= imem[i_a2[4:2]];
  end

  always @(negedge clk) begin
    if (d_we2 != 4'h0) begin
      log_sel.push_back(1'b0); log_addr.push_back(d_a2);
      log_data.push_back(d_wd2); log_we.push_back(d_we2);
    end
    if (i_we2 != 4'h0) begin
      log_sel.push_back(1'b1); log_addr.push_back(i_a2);
      log_data.push_back(i_wd2); log_we.push_back(i_we2);
    end
    if (rst_prev && !core_rst) fall_cyc = cyc;
    if (!rst_prev && core_rst) rise_cyc = cyc;
    rst_prev = core_rst;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_seg(input logic [31:0] words[$], input bit use_last, input int gap_pct,
                          output int hs_cyc, output bit timed_out);
    int guard;
    timed_out = 1'b0;
    hs_cyc = -1;
    foreach (words[i]) begin
      guard = 0;
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = use_last && (i == words.size() - 1);
      while (!in_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        timed_out = 1'b1;
        break;
      end
      hs_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect_dump(input int ready_pct, output bit timed_out);
    int guard, prev_hs;
    logic stalled, ps, pl;
    logic [31:0] pd;
    dump_data.delete(); dump_sel.delete(); dump_last.delete();
    unstable = 0; min_gap = 1000; first_valid_cyc = -1;
    guard = 0; prev_hs = -1; stalled = 1'b0; pd = '0; ps = 1'b0; pl = 1'b0;
    while (dump_data.size() < 2*W && guard < 2000) begin
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stalled && (out_data !== pd || out_sel !== ps || out_last !== pl)) unstable++;
        if (out_ready) begin
          dump_data.push_back(out_data); dump_sel.push_back(out_sel); dump_last.push_back(out_last);
          $display("dump sel=%0d data=%h last=%0d cyc=%0d", out_sel, out_data, out_last, cyc);
          if (prev_hs >= 0 && cyc - prev_hs < min_gap) min_gap = cyc - prev_hs;
          prev_hs = cyc;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; pd = out_data; ps = out_sel; pl = out_last;
        end
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    timed_out = (dump_data.size() < 2*W);
  endtask

  task automatic wait_run(input string name);
    int guard;
    guard = 0;
    while (core_rst !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (core_rst !== 1'b0) begin
      bad++; $display("FAIL %s wait_run: core_rst=%b required 0", name, core_rst);
    end
  endtask

  task automatic test_reset();
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset core_rst: got %b want 1", core_rst); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL reset out_valid/last: got %b%b want 00", out_valid, out_last); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset busy/done: got %b%b want 00", busy, done); end
    total++; if (d_a2 !== 0 || i_a2 !== 0 || d_wd2 !== 0 || i_wd2 !== 0) begin bad++; $display("FAIL reset a2/wd2: got %h %h %h %h want 0", d_a2, i_a2, d_wd2, i_wd2); end
    total++; if (d_we2 !== 0 || i_we2 !== 0) begin bad++; $display("FAIL reset we2: got %h %h want 0", d_we2, i_we2); end
    total++; if (out_data !== 0 || out_sel !== 1'b0) begin bad++; $display("FAIL reset out_data/sel: got %h %b want 0 0", out_data, out_sel); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || core_rst !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL idle: busy=%b core_rst=%b in_ready=%b want 0 1 0", busy, core_rst, in_ready); end
    $display("test_reset checked");
  endtask

  task automatic test_sequence(input string name, input logic [31:0] dw[$], input bit dl,
                               input logic [31:0] iw[$], input bit il, input int gap,
                               input int rdy, input bit poke);
    int hs_d, hs_i, n, idx;
    bit to;
    logic esel;
    logic [31:0] ed;
    log_sel.delete(); log_addr.delete(); log_data.delete(); log_we.delete();
    fall_cyc = -1; rise_cyc = -1;
    pulse_start();
    total++; if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL %s start: in_ready=%b busy=%b done=%b want 1 1 0", name, in_ready, busy, done); end
    load_seg(dw, dl, gap, hs_d, to);
    total++; if (to) begin bad++; $display("FAIL %s load_d timeout: in_ready=%b want 1", name, in_ready); end
    if (poke) pulse_start();
    load_seg(iw, il, gap, hs_i, to);
    total++; if (to) begin bad++; $display("FAIL %s load_i timeout: in_ready=%b want 1", name, in_ready); end
    if (poke) begin
      wait_run(name);
      repeat (5) @(negedge clk);
      pulse_start();
    end
    collect_dump(rdy, to);
    total++; if (to) begin bad++; $display("FAIL %s dump timeout: words=%0d want %0d", name, dump_data.size(), 2*W); end
    foreach (dw[i]) exp_mem[0][i] = dw[i];
    foreach (iw[i]) exp_mem[1][i] = iw[i];
    n = dw.size() + iw.size();
    total++; if (log_addr.size() != n) begin bad++; $display("FAIL %s write_count: got %0d want %0d", name, log_addr.size(), n); end
    for (int j = 0; j < n && j < log_addr.size(); j++) begin
      esel = (j >= dw.size());
      idx  = esel ? j - dw.size() : j;
      ed   = esel ? iw[idx] : dw[idx];
      total++;
      if ({log_sel[j], log_addr[j], log_data[j], log_we[j]} !== {esel, 32'(idx*4), ed, 4'hF}) begin
        bad++; $display("FAIL %s write[%0d]: got sel=%b a=%h d=%h we=%h want sel=%b a=%h d=%h we=F",
                        name, j, log_sel[j], log_addr[j], log_data[j], log_we[j], esel, 32'(idx*4), ed);
      end
    end
    total++; if (fall_cyc - hs_i != RSTC + 1) begin bad++; $display("FAIL %s core_rst_fall: got %0d cycles want %0d", name, fall_cyc - hs_i, RSTC + 1); end
    total++; if (rise_cyc - fall_cyc != RUNC) begin bad++; $display("FAIL %s run_len: got %0d want %0d", name, rise_cyc - fall_cyc, RUNC); end
    total++; if (first_valid_cyc - rise_cyc != 2) begin bad++; $display("FAIL %s first_valid: got %0d want 2", name, first_valid_cyc - rise_cyc); end
    for (int j = 0; j < dump_data.size(); j++) begin
      total++;
      if ({dump_data[j], dump_sel[j], dump_last[j]} !== {exp_mem[j/W][j%W], (j >= W), ((j % W) == W - 1)}) begin
        bad++; $display("FAIL %s dump[%0d]: got d=%h sel=%b last=%b want d=%h sel=%b last=%b", name, j,
                        dump_data[j], dump_sel[j], dump_last[j], exp_mem[j/W][j%W], (j >= W), ((j % W) == W - 1));
      end
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL %s stall_stability: got %0d changes want 0", name, unstable); end
    total++; if (min_gap < 3) begin bad++; $display("FAIL %s dump_rate: got gap %0d want >=3", name, min_gap); end
    total++; if (done !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1) begin bad++; $display("FAIL %s done: done=%b busy=%b core_rst=%b want 1 0 1", name, done, busy, core_rst); end
    $display("sequence %s: %0d data words, %0d inst words", name, dw.size(), iw.size());
  endtask

  task automatic rand_words(input int n, output logic [31:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back($urandom);
  endtask

  task automatic test_short_load();
    logic [31:0] dq[$], iq[$];
    dq = '{32'h11, 32'h22, 32'h33};
    iq = '{32'hAA, 32'hBB};
    test_sequence("short_load", dq, 1'b1, iq, 1'b1, 0, 100, 1'b0);
  endtask

  task automatic test_full_segment();
    logic [31:0] dq[$], iq[$];
    rand_words(W, dq);
    rand_words(1, iq);
    test_sequence("full_segment", dq, 1'b0, iq, 1'b1, 0, 100, 1'b0);
  endtask

  task automatic test_dump_backpressure();
    logic [31:0] dq[$], iq[$];
    for (int r = 0; r < 3; r++) begin
      rand_words($urandom_range(1, W), dq);
      rand_words($urandom_range(1, W), iq);
      test_sequence("backpressure", dq, (dq.size() < W) ? 1'b1 : 1'($urandom_range(1)),
                    iq, (iq.size() < W) ? 1'b1 : 1'($urandom_range(1)), 25, 30, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dq[$], iq[$];
    rand_words(W, dq);
    rand_words(W, iq);
    test_sequence("back_to_back_a", dq, 1'b1, iq, 1'b0, 0, 100, 1'b0);
    rand_words(W, dq);
    rand_words(2, iq);
    test_sequence("back_to_back_b", dq, 1'b1, iq, 1'b1, 0, 100, 1'b0);
  endtask

  task automatic test_start_handling();
    logic [31:0] dq[$], iq[$];
    total++; if (done !== 1'b1) begin bad++; $display("FAIL start_handling pre_done: got %b want 1", done); end
    rand_words(4, dq);
    rand_words(3, iq);
    test_sequence("start_handling", dq, 1'b1, iq, 1'b1, 10, 60, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] dq[$], iq[$];
    int hs;
    bit to;
    rand_words(5, dq);
    rand_words(4, iq);
    pulse_start();
    load_seg(dq, 1'b1, 0, hs, to);
    load_seg(iq, 1'b1, 0, hs, to);
    foreach (dq[i]) exp_mem[0][i] = dq[i];
    foreach (iq[i]) exp_mem[1][i] = iq[i];
    wait_run("reset_mid_run");
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (core_rst !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid_run async: core_rst=%b busy=%b want 1 0", core_rst, busy); end
    total++; if (d_we2 !== 0 || i_we2 !== 0 || in_ready !== 1'b0) begin bad++; $display("FAIL reset_mid_run outputs: we2=%h %h in_ready=%b want 0 0 0", d_we2, i_we2, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || core_rst !== 1'b1) begin bad++; $display("FAIL reset_mid_run idle: busy=%b done=%b core_rst=%b want 0 0 1", busy, done, core_rst); end
    rand_words(3, dq);
    rand_words(6, iq);
    test_sequence("after_run_reset", dq, 1'b1, iq, 1'b1, 15, 50, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] dq[$], iq[$];
    int hs;
    bit to;
    rand_words(3, dq);
    pulse_start();
    load_seg(dq, 1'b0, 0, hs, to);
    total++; if (d_we2 !== 4'hF || d_a2 !== 32'h8) begin bad++; $display("FAIL reset_mid_load pre: we2=%h a2=%h want F 8", d_we2, d_a2); end
    #2 rst = 1'b1;
    #1;
    total++; if (d_we2 !== 0 || d_a2 !== 0 || in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid_load async: we2=%h a2=%h in_ready=%b busy=%b want 0 0 0 0", d_we2, d_a2, in_ready, busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rand_words(5, dq);
    rand_words(2, iq);
    test_sequence("after_load_reset", dq, 1'b1, iq, 1'b1, 0, 100, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin
      dmem[i] = $urandom; imem[i] = $urandom;
      exp_mem[0][i] = dmem[i]; exp_mem[1][i] = imem[i];
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_short_load();
    test_full_segment();
    test_dump_backpressure();
    test_back_to_back();
    test_start_handling();
    test_reset_mid_run();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
